// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if
//   Bundles the handshake and HI/LO access signals between the control
//   unit / datapath (master) and the iterative multiply/divide unit (slave).
//   start/op/src_a/src_b   launch an operation (op: 00 MULT, 01 MULTU,
//                          10 DIV, 11 DIVU)
//   hi_we/lo_we/wr_data    MTHI / MTLO writes
//   busy/done              operation in flight / one-cycle completion pulse
//   hi/lo                  architectural HI and LO registers
interface mult_div_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, src_a, src_b, hi_we, lo_we, wr_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, hi_we, lo_we, wr_data,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative 32-bit MIPS multiply/divide unit (MULT, MULTU, DIV, DIVU)
//   holding the architectural HI/LO registers. One radix-2 step per cycle:
//   shift-add for multiply, restoring shift-subtract for divide. Signed ops
//   run on operand magnitudes and the sign is fixed up in a final cycle.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous, active-low reset (clears HI/LO, aborts any op)
//     bus  mult_div_unit_if.slave (start/op/operands, MTHI/MTLO, busy/done,
//          hi/lo)
module mult_div_unit (
  input  logic             clk,
  input  logic             rst,
  mult_div_unit_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        neg_q, neg_d;      // negate product / quotient
  logic        rneg_q, rneg_d;    // negate remainder (dividend was negative)
  logic        dz_q, dz_d;        // divide by zero
  logic [31:0] opnd_q, opnd_d;    // multiplicand or divisor magnitude
  logic [63:0] acc_q, acc_d;      // product accumulator or {remainder, quotient}
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        signed_op;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_trial;
  logic [31:0] div_diff;
  logic        div_ge;
  logic [63:0] mul_step, div_step;
  logic [63:0] prod_fix;

  always_comb begin
    signed_op = ~bus.op[0];
    a_mag = (signed_op && bus.src_a[31]) ? -bus.src_a : bus.src_a;
    b_mag = (signed_op && bus.src_b[31]) ? -bus.src_b : bus.src_b;

    // Multiply: the multiplier sits in acc[31:0] and is consumed LSB first
    // while the partial product grows into the upper half.
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_step = {mul_sum, acc_q[31:1]};

    // Divide: trial remainder is the upper half shifted left by one with the
    // next dividend bit. A successful subtraction always leaves a value below
    // the divisor, so 32 bits of difference are enough.
    div_trial = acc_q[63:31];
    div_ge    = div_trial >= {1'b0, opnd_q};
    div_diff  = div_trial[31:0] - opnd_q;
    div_step  = {(div_ge ? div_diff : div_trial[31:0]), acc_q[30:0], div_ge};

    prod_fix = neg_q ? -acc_q : acc_q;

    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          is_div_d = bus.op[1];
          neg_d    = signed_op && (bus.src_a[31] ^ bus.src_b[31]);
          rneg_d   = signed_op && bus.src_a[31];
          dz_d     = bus.op[1] && (bus.src_b == 32'd0);
          opnd_d   = bus.op[1] ? b_mag : a_mag;
          acc_d    = {32'd0, (bus.op[1] ? a_mag : b_mag)};
          cnt_d    = 5'd31;
          busy_d   = 1'b1;
          state_d  = RUN;
        end else begin
          if (bus.hi_we) hi_d = bus.wr_data;
          if (bus.lo_we) lo_d = bus.wr_data;
        end
      end
      RUN: begin
        acc_d = is_div_q ? div_step : mul_step;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = FIX;
      end
      FIX: begin
        if (is_div_q) begin
          // With a zero divisor every trial subtract succeeds, so the
          // remainder is the dividend magnitude; re-signing it restores
          // src_a exactly. Only the quotient needs forcing.
          hi_d = rneg_q ? -acc_q[63:32] : acc_q[63:32];
          lo_d = dz_q ? 32'hFFFF_FFFF : (neg_q ? -acc_q[31:0] : acc_q[31:0]);
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      opnd_q   <= 32'd0;
      acc_q    <= 64'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
//   Scoreboard bench for mult_div_unit: expected {hi,lo} pairs are queued when
//   an operation is launched and compared by a monitor on each done pulse.
module tb_mult_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mult_div_unit_if bus();

  mult_div_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_exp;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model built from the language's own arithmetic.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'b00: model = sa * sb;
      2'b01: model = ua * ub;
      2'b10: begin
        if (b == 32'd0) model = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          model = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) model = {a, 32'hFFFF_FFFF};
        else model = {a % b, a / b};
      end
    endcase
  endfunction

  // Scoreboard monitor.
  always @(posedge clk) begin
    #1;
    if (bus.done) begin
      if (exp_q.size() == 0) check_val("spurious_done", 64'd1, 64'd0);
      else begin
        mon_exp = exp_q.pop_front();
        check_val("result", {bus.hi, bus.lo}, mon_exp);
      end
    end
  end

  // Drive a start, optionally with a concurrent MTHI, and step past E0.
  task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic push, input logic [63:0] expv, input logic with_hi_we);
    if (push) exp_q.push_back(expv);
    bus.op      = op;
    bus.src_a   = a;
    bus.src_b   = b;
    bus.start   = 1'b1;
    bus.hi_we   = with_hi_we;
    bus.wr_data = 32'hDEAD_BEEF;
    tick();
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.src_a = $urandom;
    bus.src_b = $urandom;
    check_val("busy_after_start", {63'd0, bus.busy}, 64'd1);
  endtask

  // n = edges already passed since (and including) E0.
  task automatic wait_done(input int start_n, input string tag);
    int   n;
    logic busy_ok;
    n = start_n;
    busy_ok = 1'b1;
    while (!bus.done && n < 40) begin
      if (!bus.busy) busy_ok = 1'b0;
      tick();
      n++;
    end
    check_val({tag, "_latency"}, 64'(n), 64'd34);
    check_val({tag, "_busy_held"}, {63'd0, busy_ok}, 64'd1);
    check_val({tag, "_busy_clear"}, {63'd0, bus.busy}, 64'd0);
    tick();
    check_val({tag, "_done_pulse"}, {63'd0, bus.done}, 64'd0);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] expv, input string tag);
    launch(op, a, b, 1'b1, expv, 1'b0);
    wait_done(1, tag);
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.src_a = 32'd0; bus.src_b = 32'd0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wr_data = 32'd0;

    // Reset state
    tick(); tick();
    check_val("rst_busy", {63'd0, bus.busy}, 64'd0);
    check_val("rst_done", {63'd0, bus.done}, 64'd0);
    check_val("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    rst = 1'b1;
    tick();

    // MTHI / MTLO
    bus.hi_we = 1'b1; bus.wr_data = 32'h1234_5678;
    tick();
    bus.hi_we = 1'b0;
    check_val("mthi", {32'd0, bus.hi}, 64'h1234_5678);
    bus.lo_we = 1'b1; bus.wr_data = 32'h9ABC_DEF0;
    tick();
    bus.lo_we = 1'b0;
    check_val("mtlo", {bus.hi, bus.lo}, 64'h1234_5678_9ABC_DEF0);

    // Directed operations
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "multu_max");
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5,         64'hFFFF_FFFF_FFFF_FFF1, "mult_neg");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, "div_neg");
    run_op(2'b11, 32'd100,       32'd0,         64'h0000_0064_FFFF_FFFF, "divu_zero");
    run_op(2'b10, 32'hFFFF_FF9C, 32'd0,         64'hFFFF_FF9C_FFFF_FFFF, "div_zero_neg");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, "div_min");

    // Start and MTHI while busy are ignored
    launch(2'b11, 32'd17, 32'd5, 1'b1, 64'h0000_0002_0000_0003, 1'b0);
    repeat (3) tick();
    bus.start = 1'b1; bus.op = 2'b01; bus.src_a = 32'd2; bus.src_b = 32'd2;
    tick();
    bus.start = 1'b0;
    bus.hi_we = 1'b1; bus.wr_data = 32'hAAAA_AAAA;
    tick();
    bus.hi_we = 1'b0;
    check_val("hi_hold_busy", {32'd0, bus.hi}, 64'd0);
    wait_done(6, "divu_ignore");
    repeat (40) tick();

    // Start plus MTHI in the same cycle: only the result lands in HI
    launch(2'b01, 32'd3, 32'd4, 1'b1, 64'd12, 1'b1);
    check_val("hi_hold_start", {32'd0, bus.hi}, 64'd2);
    wait_done(1, "multu_hi_we");

    // Reset mid-operation
    launch(2'b00, 32'd123, 32'd456, 1'b0, 64'd0, 1'b0);
    repeat (9) tick();
    rst = 1'b0;
    tick();
    check_val("midrst_busy", {63'd0, bus.busy}, 64'd0);
    check_val("midrst_done", {63'd0, bus.done}, 64'd0);
    check_val("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
    rst = 1'b1;
    repeat (40) tick();
    run_op(2'b00, 32'd7, 32'hFFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFD6, "mult_after_rst");

    // Random operations against the model
    for (int i = 0; i < 8; i++) begin
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
      if (i % 2 == 0 && $urandom_range(0, 1) == 1) rb = -rb;
      run_op(rop, ra, rb, model(rop, ra, rb), "random");
    end

    check_val("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
